// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: drives the zero-latency ROM from the PC and queues
// {pc, inst} pairs in a small in-order FIFO for decode, with redirect and halt-on-zero.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DEPTH        = 2,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] deliver_cnt
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   pc_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic          halted_r;
  logic [31:0]   deliver_cnt_r;
  logic [31:0]   mem_pc_r   [DEPTH];
  logic [31:0]   mem_inst_r [DEPTH];

  logic not_empty_s;
  logic full_s;
  logic pop_s;
  logic can_push_s;
  logic is_end_s;
  logic push_s;

  // Handshake and push/pop qualification; a redirect blocks both transfer directions.
  assign not_empty_s = (count_r != {(AW+1){1'b0}});
  assign full_s      = (count_r == FULL_CNT);
  assign out_valid   = not_empty_s & ~redirect_valid;
  assign pop_s       = out_valid & out_ready;
  assign can_push_s  = ~halted_r & ~redirect_valid & (~full_s | pop_s);
  assign is_end_s    = HALT_ON_ZERO & (imem_inst == 32'h0000_0000);
  assign push_s      = can_push_s & ~is_end_s;

  assign imem_addr   = pc_r;
  assign halted      = halted_r;
  assign deliver_cnt = deliver_cnt_r;

  // Head-of-queue output mux, forced to zero when the FIFO is empty.
  always_comb begin
    out_inst = 32'h0000_0000;
    out_pc   = 32'h0000_0000;
    if (not_empty_s) begin
      out_inst = mem_inst_r[rd_ptr_r];
      out_pc   = mem_pc_r[rd_ptr_r];
    end else begin
      out_inst = 32'h0000_0000;
      out_pc   = 32'h0000_0000;
    end
  end

  // FIFO storage; cleared on reset so no X can reach the outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_r[i]   <= 32'h0000_0000;
        mem_inst_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      mem_pc_r[wr_ptr_r]   <= pc_r;
      mem_inst_r[wr_ptr_r] <= imem_inst;
    end else begin
      mem_pc_r[wr_ptr_r]   <= mem_pc_r[wr_ptr_r];
      mem_inst_r[wr_ptr_r] <= mem_inst_r[wr_ptr_r];
    end
  end

  // PC, pointers, occupancy, halt flag and delivery counter; redirect wins over everything.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_r          <= RESET_PC;
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      count_r       <= {(AW+1){1'b0}};
      halted_r      <= 1'b0;
      deliver_cnt_r <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc_r     <= {redirect_pc[31:2], 2'b00};
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      halted_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
        pc_r     <= pc_r + 32'd4;
      end
      if (can_push_s & is_end_s) begin
        halted_r <= 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r      <= rd_ptr_r + PTR_ONE;
        deliver_cnt_r <= deliver_cnt_r + 32'd1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] deliver_cnt;

  inst_fetch_queue #(
    .RESET_PC(32'h0000_0000), .DEPTH(DEPTH), .HALT_ON_ZERO(1'b1)
  ) dut (
    .clk(clk), .clrn(clrn), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .deliver_cnt(deliver_cnt)
  );

  always #5 clk = ~clk;

  // Zero-latency ROM: 256 words, the end-of-program word lives at 0xC0.
  logic [31:0] rom [256];
  assign imem_inst = rom[imem_addr[9:2]];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic        m_halted;
  logic [31:0] m_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = 32'h0000_0000;
    m_halted = 1'b0;
    m_cnt    = 32'h0000_0000;
  endtask

  // Assert reset now (may be between edges), check reset outputs, release at next negedge.
  task automatic do_reset();
    clrn = 1'b0;
    model_reset();
    #1;
    chk("rst_addr",  imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'b0, out_valid}, 32'h0000_0000);
    chk("rst_pc",    out_pc, 32'h0000_0000);
    chk("rst_inst",  out_inst, 32'h0000_0000);
    chk("rst_halt",  {31'b0, halted}, 32'h0000_0000);
    chk("rst_cnt",   deliver_cnt, 32'h0000_0000);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  // One cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        exp_valid;
    logic [31:0] w;
    ent_t        e;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    exp_valid = (q.size() != 0) && !rv;
    chk("imem_addr",   imem_addr, m_pc);
    chk("out_valid",   {31'b0, out_valid}, {31'b0, exp_valid});
    chk("out_pc",      out_pc,   (q.size() != 0) ? q[0].pc   : 32'h0000_0000);
    chk("out_inst",    out_inst, (q.size() != 0) ? q[0].inst : 32'h0000_0000);
    chk("halted",      {31'b0, halted}, {31'b0, m_halted});
    chk("deliver_cnt", deliver_cnt, m_cnt);
    w = rom[m_pc[9:2]];
    @(posedge clk);
    if (rv) begin
      q.delete();
      m_pc     = rpc & 32'hFFFF_FFFC;
      m_halted = 1'b0;
    end else begin
      if (exp_valid && rdy) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (!m_halted && q.size() < DEPTH) begin
        if (w == 32'h0000_0000) begin
          m_halted = 1'b1;
        end else begin
          e.pc   = m_pc;
          e.inst = w;
          q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    clrn           = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    for (int i = 0; i < 256; i++) begin
      rom[i] = {$urandom} | 32'h0000_0001 | (32'(i) << 24);
    end
    rom[48] = 32'h0000_0000;

    // Streaming from reset
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    chk("s1_cnt", deliver_cnt, 32'd3);

    // Backpressure from reset, then drain
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
    chk("s2_addr", imem_addr, 32'h0000_0008);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

    // Redirect while full
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0045);
    chk("s3_addr", imem_addr, 32'h0000_0044);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

    // Run into the zero word at 0xC0
    do_reset();
    for (int i = 0; i < 52; i++) step(1'b1, 1'b0, 32'h0);
    chk("s4_cnt",  deliver_cnt, 32'd48);
    chk("s4_addr", imem_addr, 32'h0000_00C0);
    chk("s4_halt", {31'b0, halted}, 32'h0000_0001);

    // Redirect out of halt
    step(1'b1, 1'b1, 32'h0000_0010);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset between edges with entries queued
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

    // Random traffic with occasional redirects
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           32'($urandom_range(0, 1023)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the combinational instruction ROM.
- Holds the PC and drives the ROM address. It captures the returned word into a small in-order FIFO together with its PC.
- Delivers {pc, inst} pairs to decode over a valid/ready handshake.
- Supports control-flow redirect (flushes the FIFO) and halts on the all-zero end-of-program word.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, FIFO entries. Power of two, ≥2.
- HALT_ON_ZERO, 1, when 1, fetching inst==32'h0 stops fetch instead of enqueuing it.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- imem_addr  out  32  ROM byte address; equals the PC register. The ROM returns the word in the same cycle (zero latency).
- imem_inst  in  32  ROM read data for imem_addr.
- out_valid  out  1  FIFO head valid toward decode.
- out_ready  in  1  decode accepts the head.
- out_inst  out  32  head instruction; 0 when FIFO empty.
- out_pc  out  32  head PC; 0 when FIFO empty.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- halted  out  1  fetch stopped on zero word.
- deliver_cnt  out  32  count of completed out handshakes; wraps at 2^32.

Behaviour:
- Reset (clrn=0, async): pc=RESET_PC, FIFO empty (rd/wr pointers 0, count 0), halted=0, deliver_cnt=0. Consequently out_valid=0, out_inst=0, out_pc=0, imem_addr=RESET_PC. Deasserting clrn mid-stream discards all in-flight state.
- Definitions:
  - pop = out_valid & out_ready.
  - out_valid = (count!=0) & ~redirect_valid. No transfer occurs in a redirect cycle.
  - full = (count==DEPTH).
  - can_push = ~halted & ~redirect_valid & (~full | pop). Simultaneous push and pop when full is allowed; count is unchanged.
  - is_end = HALT_ON_ZERO & (imem_inst==32'h0).
- Normal fetch: if can_push & ~is_end:
  - write {pc, imem_inst} at wr_ptr;
  - pc <= pc+4 (wraps modulo 2^32);
  - count +1 (net 0 if pop).
- Throughput: one instruction per cycle when out_ready is held high. Latency: a word fetched at edge N is visible on out_* after edge N.
- Backpressure: if full & ~pop, no push. PC and imem_addr hold, and no ROM word is lost.
- End word: if can_push & is_end:
  - no push; pc holds (imem_addr stays at the zero word);
  - halted <= 1.
  - Entries already queued continue to drain normally.
  - With HALT_ON_ZERO=0, the zero word is enqueued like any other instruction.
- Redirect (highest priority, any state including halted or full):
  - FIFO cleared (pointers 0, count 0);
  - pc <= {redirect_pc[31:2], 2'b00};
  - halted <= 0;
  - no push and no pop that cycle;
  - deliver_cnt unchanged.
  - Fetch resumes at the next edge from the new PC.
- deliver_cnt increments by 1 on each pop.
- Output mux: out_inst/out_pc are read from rd_ptr when count!=0, else 0.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- No X may propagate to outputs after reset.

Test Plan:
1. Release reset with out_ready=1 and a ROM of distinct words → imem_addr=0x0 first cycle. out_valid rises after the first edge with out_pc=0x0, then 0x4, 0x8 on consecutive cycles. deliver_cnt=3 after 3 handshakes.
2. out_ready=0 for 6 cycles from reset → FIFO holds pc 0x0,0x4. imem_addr holds 0x8 and out_pc stays 0x0. Raising out_ready delivers 0x0,0x4,0x8 in order with no gap or duplicate.
3. FIFO full, redirect_valid=1 with redirect_pc=0x45 → out_valid=0 that cycle, next imem_addr=0x44. First delivered pc=0x44; old entries never appear.
4. ROM zero word at 0xC0, out_ready=1 → pcs 0x00..0xBC delivered. halted=1 after the edge where imem_addr=0xC0, imem_addr stays 0xC0, out_valid=0 after drain, deliver_cnt=48.
5. While halted, redirect to 0x10 → halted=0 next cycle and delivery resumes at 0x10, 0x14.
6. Pulse clrn low asynchronously mid-stream (between edges) with FIFO non-empty → outputs immediately out_valid=0, imem_addr=RESET_PC, deliver_cnt=0. Restart behaves as scenario 1.
